// File: rtl/integ_sequencer_pkg.sv
// integ_sequencer_pkg: state encoding and sizing helpers for the integration sequencer
package integ_sequencer_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_INTEG  = 2'd2;
  function automatic int acc_w(input int max_log2);
    return max_log2 + 1;
  endfunction
  function automatic int unsigned clamp_k(input int unsigned w, input int unsigned m);
    return (w > m) ? m : w;
  endfunction
endpackage

// File: rtl/integ_sequencer_window_timer.sv
// window_timer: counts 0..2^k-1 with a last pulse on the final cycle, then wraps
module window_timer #(
  parameter int MAX_LOG2 = 8,
  parameter int LOG2_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic              en,
  input  logic [LOG2_W-1:0] k,
  output logic              last
);
  localparam int W = MAX_LOG2 + 1;
  logic [MAX_LOG2-1:0] r_cnt;
  logic [LOG2_W-1:0]   r_k;
  logic [W-1:0]        w_mask;
  assign w_mask = (W'(1) << r_k) - W'(1);
  assign last   = en && ({1'b0, r_cnt} == w_mask);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
      r_k   <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= '0;
      r_k   <= k;
    end else if (en) begin
      r_cnt <= last ? '0 : r_cnt + MAX_LOG2'(1);
    end
  end
endmodule

// File: rtl/integ_sequencer.sv
// integ_sequencer: settle/integrate windows of 2^k cycles over a 1-bit stream,
// results on valid/ready with sticky overrun and a hysteresis level output
module integ_sequencer
  import integ_sequencer_pkg::*;
#(
  parameter int MAX_LOG2 = 8,
  parameter int LOG2_W   = 4,
  parameter int ACC_W    = acc_w(MAX_LOG2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sig,
  input  logic              start,
  input  logic              stop,
  input  logic              cont,
  input  logic [LOG2_W-1:0] win_log2,
  input  logic [3:0]        settle_n,
  input  logic [ACC_W-1:0]  thr_hi,
  input  logic [ACC_W-1:0]  thr_lo,
  output logic              busy,
  output logic [ACC_W-1:0]  res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              level,
  output logic              overrun
);
  logic [1:0]        r_state;
  logic [3:0]        r_settle;
  logic              r_cont;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_res;
  logic              r_valid;
  logic              r_level;
  logic              r_overrun;
  logic              w_accept;
  logic              w_last;
  logic              w_new;
  logic              w_level;
  logic [ACC_W-1:0]  w_sum;
  logic [LOG2_W-1:0] w_k;
  assign w_k       = LOG2_W'(clamp_k(32'(win_log2), MAX_LOG2));
  assign w_accept  = (r_state == ST_IDLE) && start && !stop;
  assign w_sum     = r_acc + ACC_W'(sig);
  assign w_new     = (r_state == ST_INTEG) && w_last && !stop;
  // thr_hi wins over thr_lo so misordered thresholds resolve deterministically
  assign w_level   = (w_sum >= thr_hi) ? 1'b1 : (w_sum <= thr_lo) ? 1'b0 : r_level;
  assign busy      = r_state != ST_IDLE;
  assign res       = r_res;
  assign res_valid = r_valid;
  assign level     = r_level;
  assign overrun   = r_overrun;
  window_timer #(.MAX_LOG2(MAX_LOG2), .LOG2_W(LOG2_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (w_accept),
    .clr  (stop),
    .en   (busy),
    .k    (w_k),
    .last (w_last)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_settle  <= '0;
      r_cont    <= 1'b0;
      r_acc     <= '0;
      r_res     <= '0;
      r_valid   <= 1'b0;
      r_level   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (stop) begin
        r_state <= ST_IDLE;
        r_acc   <= '0;
      end else if (w_accept) begin
        r_state  <= (settle_n != 4'd0) ? ST_SETTLE : ST_INTEG;
        r_settle <= settle_n;
        r_cont   <= cont;
        r_acc    <= '0;
      end else if (r_state == ST_SETTLE && w_last) begin
        r_settle <= r_settle - 4'd1;
        if (r_settle == 4'd1) r_state <= ST_INTEG;
      end else if (r_state == ST_INTEG) begin
        r_acc <= w_last ? '0 : w_sum;
        if (w_last && !r_cont) r_state <= ST_IDLE;
      end
      r_valid   <= w_new | (r_valid & ~res_ready);
      r_overrun <= w_accept ? 1'b0 : r_overrun | (w_new & r_valid & ~res_ready);
      if (w_new) begin
        r_res   <= w_sum;
        r_level <= w_level;
      end
    end
  end
endmodule

// File: tb/tb_integ_sequencer.sv
// tb_integ_sequencer: directed scenario tests with hand-computed expectations
module tb_integ_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sig = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       cont = 1'b0;
  logic [3:0] win_log2 = '0;
  logic [3:0] settle_n = '0;
  logic [8:0] thr_hi = '0;
  logic [8:0] thr_lo = '0;
  logic       busy;
  logic [8:0] res;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic       level;
  logic       overrun;
  int checks = 0;
  int fails = 0;

  integ_sequencer dut (
    .clk(clk), .rst(rst), .sig(sig), .start(start), .stop(stop), .cont(cont),
    .win_log2(win_log2), .settle_n(settle_n), .thr_hi(thr_hi), .thr_lo(thr_lo),
    .busy(busy), .res(res), .res_valid(res_valid), .res_ready(res_ready),
    .level(level), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] k, input logic [3:0] sn, input logic c);
    win_log2 = k;
    settle_n = sn;
    cont = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    sig = 1'b1;
    repeat (50) tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", res_valid); end
    checks++; if (res !== 9'd0) begin fails++; $display("FAIL reset_res got %0d exp 0", res); end
    checks++; if (level !== 1'b0) begin fails++; $display("FAIL reset_level got %b exp 0", level); end
  endtask

  task automatic test_single();
    thr_hi = 9'd8;
    thr_lo = 9'd2;
    sig = 1'b1;
    do_start(4'd4, 4'd0, 1'b0);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy_rise got %b exp 1", busy); end
    repeat (15) tick();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL single_early got valid=%b busy=%b exp 0/1", res_valid, busy); end
    tick();
    checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", res_valid); end
    checks++; if (res !== 9'd16) begin fails++; $display("FAIL single_res got %0d exp 16", res); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_fall got %b exp 0", busy); end
    checks++; if (level !== 1'b1) begin fails++; $display("FAIL single_level got %b exp 1", level); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL single_handshake got %b exp 0", res_valid); end
  endtask

  task automatic test_settle();
    do_start(4'd3, 4'd2, 1'b0);
    for (int i = 0; i < 24; i++) begin
      sig = (i % 2 == 0);
      if (i == 23) begin
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL settle_early got %b exp 0", res_valid); end
      end
      tick();
    end
    checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL settle_valid got %b exp 1", res_valid); end
    checks++; if (res !== 9'd4) begin fails++; $display("FAIL settle_res got %0d exp 4", res); end
    checks++; if (level !== 1'b1) begin fails++; $display("FAIL settle_level_hold got %b exp 1", level); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_cont();
    sig = 1'b1;
    do_start(4'd2, 4'd0, 1'b1);
    repeat (4) tick();
    checks++; if (res_valid !== 1'b1 || res !== 9'd4) begin fails++; $display("FAIL cont_first got valid=%b res=%0d exp 1/4", res_valid, res); end
    checks++; if (overrun !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL cont_first_flags got ovr=%b busy=%b exp 0/1", overrun, busy); end
    repeat (4) tick();
    checks++; if (overrun !== 1'b1 || res !== 9'd4) begin fails++; $display("FAIL cont_overrun got ovr=%b res=%0d exp 1/4", overrun, res); end
    repeat (3) tick();
    res_ready = 1'b1;
    tick();
    checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL cont_same_cycle got %b exp 1", res_valid); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin fails++; $display("FAIL cont_stop got busy=%b valid=%b exp 0/0", busy, res_valid); end
    checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL cont_overrun_sticky got %b exp 1", overrun); end
    do_start(4'd2, 4'd0, 1'b0);
    checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL cont_overrun_clear got %b exp 0", overrun); end
    repeat (4) tick();
    checks++; if (res_valid !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL cont_oneshot got valid=%b busy=%b exp 1/0", res_valid, busy); end
    tick();
    res_ready = 1'b0;
  endtask

  task automatic run_window(input int n, input logic exp_level);
    do_start(4'd4, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      sig = (i < n);
      tick();
    end
    checks++; if (res !== 9'(n) || res_valid !== 1'b1) begin fails++; $display("FAIL hyst_res got %0d valid=%b exp %0d", res, res_valid, n); end
    checks++; if (level !== exp_level) begin fails++; $display("FAIL hyst_level res=%0d got %b exp %b", n, level, exp_level); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_hysteresis();
    thr_hi = 9'd12;
    thr_lo = 9'd4;
    run_window(13, 1'b1);
    run_window(8, 1'b1);
    run_window(3, 1'b0);
    run_window(8, 1'b0);
  endtask

  task automatic test_abort();
    sig = 1'b1;
    do_start(4'd2, 4'd0, 1'b0);
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL abort_last got valid=%b busy=%b exp 0/0", res_valid, busy); end
    checks++; if (res !== 9'd8) begin fails++; $display("FAIL abort_res_kept got %0d exp 8", res); end
    tick();
    checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL abort_after got %b exp 0", res_valid); end
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL start_stop got busy=%b exp 0", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL start_stop_after got busy=%b exp 0", busy); end
  endtask

  task automatic test_clamp();
    sig = 1'b1;
    do_start(4'd15, 4'd0, 1'b0);
    repeat (255) tick();
    checks++; if (res_valid !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL clamp_early got valid=%b busy=%b exp 0/1", res_valid, busy); end
    tick();
    checks++; if (res_valid !== 1'b1 || res !== 9'd256) begin fails++; $display("FAIL clamp_res got valid=%b res=%0d exp 1/256", res_valid, res); end
    checks++; if (level !== 1'b1) begin fails++; $display("FAIL clamp_level got %b exp 1", level); end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b0;
    do_start(4'd4, 4'd0, 1'b0);
    repeat (5) tick();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || res !== 9'd0) begin fails++; $display("FAIL rst_mid got busy=%b valid=%b res=%0d exp 0/0/0", busy, res_valid, res); end
    checks++; if (level !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL rst_mid_flags got level=%b ovr=%b exp 0/0", level, overrun); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_release got busy=%b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_settle();
    test_cont();
    test_hysteresis();
    test_abort();
    test_clamp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
